bus_mux_arb: RTL

//  Parametrised N-way, WIDTH-bit source selector for the CPU data bus; successor to the fixed 8x1 10-bit mux.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/bus_mux_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU data-bus datapath blocks.
package cpu_pkg;

    localparam int unsigned WORD_W   = 10;
    localparam logic        MODE_SEL = 1'b0;
    localparam logic        MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans ptr+1, ptr+2, ... modulo N for the first requester.
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // Offset-major search: the first offset k whose slot (ptr+k) mod N requests wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && req[i] && ((32'(ptr) + k) % N) == i) begin
                    any    = 1'b1;
                    idx    = SEL_W'(i);
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_mux_arb.sv
// N-way bus source selector with direct or round-robin selection and a registered
// valid/ready output stage (one-cycle latency, full throughput).
module bus_mux_arb
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_req,
    output logic [N-1:0]       in_gnt,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;
    logic             out_valid_q;
    logic [SEL_W-1:0] rr_ptr_q;

    logic [N-1:0]     dir_gnt;
    logic             dir_any;
    logic [N-1:0]     rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;

    logic [N-1:0]     win_gnt;
    logic [SEL_W-1:0] win_idx;
    logic             win_any;
    logic [WIDTH-1:0] win_data;
    logic             load;

    // Compare against every legal index so sel >= N simply matches nothing.
    always_comb begin
        dir_gnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(sel) == i && in_req[i]) begin
                dir_gnt[i] = 1'b1;
            end
        end
    end

    assign dir_any = |dir_gnt;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req (in_req),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            win_gnt = rr_gnt;
            win_idx = rr_idx;
            win_any = rr_any;
        end else begin
            win_gnt = dir_gnt;
            win_idx = sel;
            win_any = dir_any;
        end
    end

    // AND-OR mux off the one-hot grant; no index ever leaves the valid range.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_gnt[i]) begin
                win_data = win_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load   = !out_valid_q || out_ready;
    assign in_gnt = (load && !rst) ? win_gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N - 1);
        end else if (load) begin
            out_valid_q <= win_any;
            if (win_any) begin
                out_data_q <= win_data;
                out_src_q  <= win_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_q <= win_idx;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
